// File: rtl/bcm_plane_shifter.sv
// bcm_plane_shifter
// Shifts one bit-plane of a HUB75-style panel row out to the panel, column by
// column, then latches it and signals the BCM timer to start the display
// period for that plane. The previous plane stays lit while the next shifts.
//
// Ports
//   clk            single clock, all logic on posedge
//   rst            asynchronous active-low reset
//   in_INIT        pulse: load plane 0 of the current row
//   in_NEXT_PLANE  pulse: load the next plane
//   in_PIXEL       pixel word for out_ADDR, valid one cycle after out_ADDR;
//                  channel k at [k*PLANES +: PLANES], k = R0,G0,B0,R1,G1,B1
//   out_ADDR       column read address
//   out_RGB0/1     panel data {B,G,R} for the upper / lower half
//   out_SCLK       panel shift clock
//   out_LATCH      panel latch strobe
//   out_OE_n       panel output enable, active-low
//   out_CONTINUE   pulse: plane latched, BCM may start timing
//   out_PLANE      plane being / last loaded
//   out_BUSY       transfer in progress (FETCH through CONT)
//   out_OVERRUN    sticky: a load request was ignored
module bcm_plane_shifter #(
  parameter int COLUMNS    = 64,
  parameter int PLANES     = 4,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_INIT,
  input  logic                  in_NEXT_PLANE,
  input  logic [6*PLANES-1:0]   in_PIXEL,
  output logic [ADDR_WIDTH-1:0] out_ADDR,
  output logic [2:0]            out_RGB0,
  output logic [2:0]            out_RGB1,
  output logic                  out_SCLK,
  output logic                  out_LATCH,
  output logic                  out_OE_n,
  output logic                  out_CONTINUE,
  output logic [2:0]            out_PLANE,
  output logic                  out_BUSY,
  output logic                  out_OVERRUN
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_LATCH    = 3'd4,
    S_CONT     = 3'd5,
    S_WAIT     = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL   = ADDR_WIDTH'(COLUMNS - 1);
  localparam logic [2:0]            LAST_PLANE = 3'(PLANES - 1);

  state_t                  state_q, state_d;
  logic [2:0]              plane_q, plane_d;
  logic [ADDR_WIDTH-1:0]   col_q, col_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              rgb0_q, rgb0_d;
  logic [2:0]              rgb1_q, rgb1_d;
  logic                    sclk_q, sclk_d;
  logic                    latch_q, latch_d;
  logic                    oe_n_q, oe_n_d;
  logic                    cont_q, cont_d;
  logic                    busy_q, busy_d;
  logic                    ovr_q, ovr_d;

  // Select bit [plane] of three consecutive channels starting at channel base.
  function automatic logic [2:0] pick_bits(input logic [6*PLANES-1:0] pix,
                                           input logic [2:0]          plane,
                                           input int                  base);
    logic [2:0]        r;
    logic [PLANES-1:0] ch;
    r = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ch   = pix[(base + i)*PLANES +: PLANES];
      ch   = ch >> plane;
      r[i] = ch[0];
    end
    return r;
  endfunction

  // Next-state logic for the FSM, datapath and registered panel outputs.
  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    col_d   = col_q;
    addr_d  = addr_q;
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    ovr_d   = ovr_q;

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (in_INIT) begin
          plane_d = 3'd0;
          col_d   = '0;
          addr_d  = '0;
          state_d = S_FETCH;
        end else if (in_NEXT_PLANE) begin
          // Only a waiting block below the last plane can advance.
          if ((state_q == S_WAIT) && (plane_q < LAST_PLANE)) begin
            plane_d = plane_q + 3'd1;
            col_d   = '0;
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        rgb0_d = pick_bits(in_PIXEL, plane_q, 0);
        rgb1_d = pick_bits(in_PIXEL, plane_q, 3);
        // Prefetch the next column; the address never runs past the row.
        if (col_q != LAST_COL) begin
          addr_d = col_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          addr_d = addr_q;
        end
        state_d = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (col_q == LAST_COL) begin
          state_d = S_LATCH;
        end else begin
          col_d   = col_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          state_d = S_SHIFT_LO;
        end
      end
      S_LATCH: begin
        state_d = S_CONT;
      end
      S_CONT: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any request arriving mid-transfer is dropped but remembered.
    if (busy_q && (in_INIT || in_NEXT_PLANE)) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_d;
    end

    // Outputs are registered alongside the state so they align with it.
    sclk_d  = (state_d == S_SHIFT_HI);
    latch_d = (state_d == S_LATCH);
    oe_n_d  = (state_d == S_LATCH) || (state_d == S_IDLE);
    cont_d  = (state_d == S_CONT);
    busy_d  = (state_d == S_FETCH) || (state_d == S_SHIFT_LO) ||
              (state_d == S_SHIFT_HI) || (state_d == S_LATCH) ||
              (state_d == S_CONT);
  end

  // State and output registers; reset blanks the panel and aborts any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      plane_q <= 3'd0;
      col_q   <= '0;
      addr_q  <= '0;
      rgb0_q  <= 3'b000;
      rgb1_q  <= 3'b000;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
      cont_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
      cont_q  <= cont_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_ADDR     = addr_q;
  assign out_RGB0     = rgb0_q;
  assign out_RGB1     = rgb1_q;
  assign out_SCLK     = sclk_q;
  assign out_LATCH    = latch_q;
  assign out_OE_n     = oe_n_q;
  assign out_CONTINUE = cont_q;
  assign out_PLANE    = plane_q;
  assign out_BUSY     = busy_q;
  assign out_OVERRUN  = ovr_q;

endmodule

// File: tb/tb_bcm_plane_shifter.sv
// Directed bench for bcm_plane_shifter with a 4-column, 4-plane row.
module tb_bcm_plane_shifter;

  localparam int COLUMNS = 4;
  localparam int PLANES  = 4;
  localparam int AW      = 2;

  logic            clk;
  logic            rst;
  logic            in_INIT;
  logic            in_NEXT_PLANE;
  logic [23:0]     in_PIXEL;
  logic [AW-1:0]   out_ADDR;
  logic [2:0]      out_RGB0;
  logic [2:0]      out_RGB1;
  logic            out_SCLK;
  logic            out_LATCH;
  logic            out_OE_n;
  logic            out_CONTINUE;
  logic [2:0]      out_PLANE;
  logic            out_BUSY;
  logic            out_OVERRUN;

  int              n_checks;
  int              n_fail;
  int              cont_cnt;
  int              pattern;
  logic [23:0]     mem_b [4];

  bcm_plane_shifter #(.COLUMNS(COLUMNS), .PLANES(PLANES), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_INIT(in_INIT), .in_NEXT_PLANE(in_NEXT_PLANE),
    .in_PIXEL(in_PIXEL), .out_ADDR(out_ADDR), .out_RGB0(out_RGB0),
    .out_RGB1(out_RGB1), .out_SCLK(out_SCLK), .out_LATCH(out_LATCH),
    .out_OE_n(out_OE_n), .out_CONTINUE(out_CONTINUE), .out_PLANE(out_PLANE),
    .out_BUSY(out_BUSY), .out_OVERRUN(out_OVERRUN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous pixel memory: one cycle read latency.
  always @(posedge clk) begin
    if (pattern == 0) in_PIXEL <= 24'h000005;
    else              in_PIXEL <= mem_b[out_ADDR];
  end

  always @(posedge clk) begin
    if (out_CONTINUE) cont_cnt <= cont_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full plane load; req[0]=INIT, req[1]=NEXT_PLANE. inj_col >= 0 pulses
  // NEXT_PLANE during SHIFT_HI of that column.
  task automatic load_plane(input logic [1:0] req, input logic [2:0] exp_plane,
                            input logic [11:0] e0, input logic [11:0] e1,
                            input int inj_col);
    @(negedge clk); in_INIT = req[0]; in_NEXT_PLANE = req[1];
    @(negedge clk); in_INIT = 1'b0; in_NEXT_PLANE = 1'b0;
    check_eq("fetch_busy", 32'(out_BUSY), 32'd1);
    check_eq("fetch_plane", 32'(out_PLANE), 32'(exp_plane));
    check_eq("fetch_sclk", 32'(out_SCLK), 32'd0);
    check_eq("fetch_addr", 32'(out_ADDR), 32'd0);
    check_eq("fetch_oe_n", 32'(out_OE_n), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); in_NEXT_PLANE = 1'b0;
      check_eq("lo_sclk", 32'(out_SCLK), 32'd0);
      check_eq("lo_addr", 32'(out_ADDR), 32'(c));
      @(negedge clk);
      check_eq("hi_sclk", 32'(out_SCLK), 32'd1);
      check_eq("hi_rgb0", 32'(out_RGB0), 32'(e0[c*3 +: 3]));
      check_eq("hi_rgb1", 32'(out_RGB1), 32'(e1[c*3 +: 3]));
      check_eq("hi_addr", 32'(out_ADDR), (c < 3) ? 32'(c + 1) : 32'd3);
      check_eq("hi_latch", 32'(out_LATCH), 32'd0);
      if (c == inj_col) in_NEXT_PLANE = 1'b1;
    end
    @(negedge clk); in_NEXT_PLANE = 1'b0;
    check_eq("latch", 32'(out_LATCH), 32'd1);
    check_eq("latch_oe_n", 32'(out_OE_n), 32'd1);
    check_eq("latch_sclk", 32'(out_SCLK), 32'd0);
    check_eq("latch_cont", 32'(out_CONTINUE), 32'd0);
    @(negedge clk);
    check_eq("cont", 32'(out_CONTINUE), 32'd1);
    check_eq("cont_oe_n", 32'(out_OE_n), 32'd0);
    check_eq("cont_latch", 32'(out_LATCH), 32'd0);
    check_eq("cont_busy", 32'(out_BUSY), 32'd1);
    @(negedge clk);
    check_eq("wait_cont", 32'(out_CONTINUE), 32'd0);
    check_eq("wait_busy", 32'(out_BUSY), 32'd0);
    check_eq("wait_oe_n", 32'(out_OE_n), 32'd0);
    check_eq("wait_plane", 32'(out_PLANE), 32'(exp_plane));
  endtask

  // Pulse a lone NEXT_PLANE and confirm nothing starts.
  task automatic ignored_next(input logic [2:0] exp_plane);
    int saw_busy;
    int c0;
    saw_busy = 0;
    c0 = cont_cnt;
    @(negedge clk); in_NEXT_PLANE = 1'b1;
    @(negedge clk); in_NEXT_PLANE = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_BUSY) saw_busy = 1;
    end
    check_eq("ign_busy", 32'(saw_busy), 32'd0);
    check_eq("ign_plane", 32'(out_PLANE), 32'(exp_plane));
    check_eq("ign_overrun", 32'(out_OVERRUN), 32'd1);
    check_eq("ign_cont", 32'(cont_cnt - c0), 32'd0);
  endtask

  initial begin
    int c0;
    n_checks = 0; n_fail = 0; cont_cnt = 0; pattern = 0;
    in_INIT = 1'b0; in_NEXT_PLANE = 1'b0;
    // {B1,G1,R1,B0,G0,R0}, 4 bits per channel
    mem_b[0] = 24'h030001;
    mem_b[1] = 24'h100020;
    mem_b[2] = 24'h002300;
    mem_b[3] = 24'h2015EF;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_addr", 32'(out_ADDR), 32'd0);
    check_eq("rst_rgb0", 32'(out_RGB0), 32'd0);
    check_eq("rst_rgb1", 32'(out_RGB1), 32'd0);
    check_eq("rst_sclk", 32'(out_SCLK), 32'd0);
    check_eq("rst_latch", 32'(out_LATCH), 32'd0);
    check_eq("rst_oe_n", 32'(out_OE_n), 32'd1);
    check_eq("rst_cont", 32'(out_CONTINUE), 32'd0);
    check_eq("rst_busy", 32'(out_BUSY), 32'd0);
    check_eq("rst_overrun", 32'(out_OVERRUN), 32'd0);
    check_eq("rst_plane", 32'(out_PLANE), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_oe_n", 32'(out_OE_n), 32'd1);

    // R0 = 4'b0101: planes 0 and 2 light red, 1 and 3 dark.
    c0 = cont_cnt;
    load_plane(2'b01, 3'd0, {4{3'b001}}, 12'h000, -1);
    load_plane(2'b10, 3'd1, 12'h000, 12'h000, -1);
    load_plane(2'b10, 3'd2, {4{3'b001}}, 12'h000, -1);
    load_plane(2'b10, 3'd3, 12'h000, 12'h000, -1);
    @(negedge clk);
    check_eq("four_conts", 32'(cont_cnt - c0), 32'd4);
    check_eq("seq_overrun", 32'(out_OVERRUN), 32'd0);
    ignored_next(3'd3);

    // Reset during SHIFT_LO of column 1 aborts the transfer.
    pattern = 1;
    @(negedge clk); in_INIT = 1'b1;
    @(negedge clk); in_INIT = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_oe_n", 32'(out_OE_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_oe_n", 32'(out_OE_n), 32'd1);
    check_eq("arst_sclk", 32'(out_SCLK), 32'd0);
    check_eq("arst_busy", 32'(out_BUSY), 32'd0);
    check_eq("arst_addr", 32'(out_ADDR), 32'd0);
    check_eq("arst_overrun", 32'(out_OVERRUN), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    c0 = cont_cnt;
    repeat (30) @(negedge clk);
    check_eq("abort_no_cont", 32'(cont_cnt - c0), 32'd0);
    check_eq("abort_busy", 32'(out_BUSY), 32'd0);

    // Per-column data, expected {col3,col2,col1,col0} each {B,G,R}.
    load_plane(2'b01, 3'd0, {3'b101, 3'b100, 3'b000, 3'b001},
                            {3'b001, 3'b000, 3'b100, 3'b010}, -1);
    load_plane(2'b10, 3'd1, {3'b011, 3'b100, 3'b010, 3'b000},
                            {3'b100, 3'b001, 3'b000, 3'b010}, -1);
    load_plane(2'b10, 3'd2, {3'b111, 3'b000, 3'b000, 3'b000}, 12'h000, -1);
    // INIT wins over NEXT_PLANE in WAIT at plane 2.
    load_plane(2'b11, 3'd0, {3'b101, 3'b100, 3'b000, 3'b001},
                            {3'b001, 3'b000, 3'b100, 3'b010}, -1);
    check_eq("both_overrun", 32'(out_OVERRUN), 32'd0);
    // NEXT_PLANE during SHIFT_HI of column 2 is dropped.
    load_plane(2'b10, 3'd1, {3'b011, 3'b100, 3'b010, 3'b000},
                            {3'b100, 3'b001, 3'b000, 3'b010}, 2);
    check_eq("midshift_overrun", 32'(out_OVERRUN), 32'd1);

    // Lone NEXT_PLANE in IDLE.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check_eq("idle_overrun_clr", 32'(out_OVERRUN), 32'd0);
    ignored_next(3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
